// File: rtl/shift_reg_universal.sv
// WIDTH-bit universal shift register with a q/q_bar output pair.
// Supports parallel load, clear, and multi-step shift/rotate operations behind a start/busy/done handshake.
module shift_reg_universal #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] d,
    input  logic             s_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             s_out,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_SHL   = 3'b010;
    localparam logic [2:0] OP_SHR   = 3'b011;
    localparam logic [2:0] OP_ROL   = 3'b100;
    localparam logic [2:0] OP_ROR   = 3'b101;
    localparam logic [2:0] OP_ASR   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] reg_q, reg_d;
    logic [WIDTH-1:0] reg_bar_q;
    logic             busy_q, done_q;
    logic             start_is_shift_s;

    // One single-bit step of a shift/rotate op; non-shift codes leave the value alone.
    function automatic logic [WIDTH-1:0] step_f(input logic [2:0] op_v,
                                                input logic [WIDTH-1:0] v,
                                                input logic fill);
        case (op_v)
            OP_SHL:  step_f = {v[WIDTH-2:0], fill};
            OP_SHR:  step_f = {fill, v[WIDTH-1:1]};
            OP_ROL:  step_f = {v[WIDTH-2:0], v[WIDTH-1]};
            OP_ROR:  step_f = {v[0], v[WIDTH-1:1]};
            OP_ASR:  step_f = {v[WIDTH-1], v[WIDTH-1:1]};
            default: step_f = v;
        endcase
    endfunction

    assign start_is_shift_s = (op != OP_HOLD) && (op != OP_LOAD) && (op != OP_CLEAR);

    // Next-state, counter and data-path computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        reg_d   = reg_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d = op;
                    if (start_is_shift_s && (amount != {AMT_W{1'b0}})) begin
                        cnt_d   = amount;
                        state_d = ST_SHIFT;
                    end else begin
                        cnt_d   = {AMT_W{1'b0}};
                        state_d = ST_DONE;
                        if (op == OP_LOAD) begin
                            reg_d = d;
                        end else if (op == OP_CLEAR) begin
                            reg_d = {WIDTH{1'b0}};
                        end else begin
                            reg_d = reg_q;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                reg_d = step_f(op_q, reg_q, s_in);
                cnt_d = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and data registers; busy/done are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {AMT_W{1'b0}};
            op_q      <= OP_HOLD;
            reg_q     <= {WIDTH{1'b0}};
            reg_bar_q <= {WIDTH{1'b1}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            reg_q     <= reg_d;
            reg_bar_q <= ~reg_d;
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign q     = reg_q;
    assign q_bar = reg_bar_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign s_out = ((op_q == OP_SHL) || (op_q == OP_ROL)) ? reg_q[WIDTH-1] : reg_q[0];

endmodule

// File: tb/tb_shift_reg_universal.sv
// Self-checking bench for shift_reg_universal: expected register values are queued
// when an operation is launched and compared as the DUT produces them.
module tb_shift_reg_universal;

    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_SHL   = 3'b010;
    localparam logic [2:0] OP_SHR   = 3'b011;
    localparam logic [2:0] OP_ROL   = 3'b100;
    localparam logic [2:0] OP_ROR   = 3'b101;
    localparam logic [2:0] OP_ASR   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [2:0] op;
    logic [2:0] amount;
    logic [7:0] d;
    logic       s_in;
    logic [7:0] q;
    logic [7:0] q_bar;
    logic       s_out;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] sb_q[$];

    shift_reg_universal #(.WIDTH(8), .AMT_W(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .amount  (amount),
        .d       (d),
        .s_in    (s_in),
        .q       (q),
        .q_bar   (q_bar),
        .s_out   (s_out),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation, wait for done and compare latency and final contents.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [2:0] a,
                          input logic [7:0] dv, input logic si,
                          input logic [7:0] exp_q, input int exp_cyc);
        int cyc;
        logic [7:0] e;
        logic [7:0] eb;
        sb_q.push_back(exp_q);
        op = o; amount = a; d = dv; s_in = si; start = 1'b1;
        tick();
        start = 1'b0; d = 8'h00; op = OP_HOLD; amount = 3'd0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            check_eq({tag, "_busy"}, busy, 1);
            tick();
            cyc++;
        end
        check_eq({tag, "_done"}, done, 1);
        check_eq({tag, "_latency"}, cyc, exp_cyc);
        check_eq({tag, "_busy_at_done"}, busy, 1);
        e  = sb_q.pop_front();
        eb = ~e;
        check_eq({tag, "_q"}, q, e);
        check_eq({tag, "_q_bar"}, q_bar, eb);
        tick();
        check_eq({tag, "_done_1cyc"}, done, 0);
        check_eq({tag, "_busy_end"}, busy, 0);
    endtask

    initial begin
        logic [7:0] e;
        int cyc;
        int seen_done;

        reset_n = 1'b0; start = 1'b0; op = OP_HOLD; amount = 3'd0; d = 8'h00; s_in = 1'b0;
        #12;
        check_eq("rst_q", q, 8'h00);
        check_eq("rst_q_bar", q_bar, 8'hFF);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        tick();
        check_eq("post_rst_q", q, 8'h00);
        check_eq("post_rst_q_bar", q_bar, 8'hFF);
        check_eq("post_rst_busy", busy, 0);

        run_op("load", OP_LOAD, 3'd0, 8'hA5, 1'b0, 8'hA5, 1);

        // SHL by 3 with per-step checks of q and s_out
        sb_q.push_back(8'hA5);
        sb_q.push_back(8'h4B);
        sb_q.push_back(8'h97);
        sb_q.push_back(8'h2F);
        op = OP_SHL; amount = 3'd3; s_in = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; op = OP_CLEAR; amount = 3'd7;
        for (int i = 1; i <= 4; i++) begin
            e = sb_q.pop_front();
            check_eq("shl_q", q, e);
            check_eq("shl_s_out", s_out, e[7]);
            check_eq("shl_busy", busy, 1);
            check_eq("shl_done", done, (i == 4) ? 1 : 0);
            if (i < 4) tick();
        end
        tick();
        check_eq("shl_done_end", done, 0);
        check_eq("shl_busy_end", busy, 0);

        run_op("ldA5", OP_LOAD, 3'd0, 8'hA5, 1'b0, 8'hA5, 1);
        run_op("ror4", OP_ROR, 3'd4, 8'h00, 1'b0, 8'h5A, 5);
        run_op("ld80", OP_LOAD, 3'd0, 8'h80, 1'b0, 8'h80, 1);
        run_op("asr2", OP_ASR, 3'd2, 8'h00, 1'b0, 8'hE0, 3);
        run_op("ld01", OP_LOAD, 3'd0, 8'h01, 1'b0, 8'h01, 1);
        run_op("rol7", OP_ROL, 3'd7, 8'h00, 1'b0, 8'h80, 8);
        run_op("shl0", OP_SHL, 3'd0, 8'h00, 1'b1, 8'h80, 1);
        run_op("hold", OP_HOLD, 3'd5, 8'h33, 1'b1, 8'h80, 1);
        run_op("clear", OP_CLEAR, 3'd0, 8'h33, 1'b1, 8'h00, 1);

        // Start while busy must be ignored
        run_op("ldF0", OP_LOAD, 3'd0, 8'hF0, 1'b0, 8'hF0, 1);
        sb_q.push_back(8'h07);
        op = OP_SHR; amount = 3'd5; s_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        op = OP_CLEAR; start = 1'b1;
        tick();
        start = 1'b0; op = OP_HOLD;
        cyc = 3;
        while (done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        check_eq("busy_ign_latency", cyc, 6);
        e = sb_q.pop_front();
        check_eq("busy_ign_q", q, e);
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done === 1'b1) seen_done++;
        end
        check_eq("busy_ign_no_extra_done", seen_done, 0);
        check_eq("busy_ign_q_hold", q, 8'h07);

        // Reset in the 2nd SHIFT cycle of ROL by 6
        run_op("ld81", OP_LOAD, 3'd0, 8'h81, 1'b0, 8'h81, 1);
        op = OP_ROL; amount = 3'd6; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_eq("midrst_pre_q", q, 8'h03);
        reset_n = 1'b0;
        #1;
        check_eq("midrst_q", q, 8'h00);
        check_eq("midrst_q_bar", q_bar, 8'hFF);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        check_eq("midrst_no_done", seen_done, 0);
        check_eq("midrst_q_after", q, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
